nonce_dispatch_ctrl: RTL and testbench
======================================

// Module: nonce_dispatch_ctrl
// PURPOSE
//  Sequences the 64-stage pipelined SHA-256 nonce hasher (1 hash/clk, fixed latency) for a search.
//  Issues one 256-bit nonce candidate per clock from a programmed 32-bit counter range,
//  tracks in-flight slots with a tag shift register, and compares retiring digests against a
//  leading-zero difficulty. Returns the first qualifying nonce/digest over a valid/ready port.
// PARAMETERS
//  PIPE_LATENCY  64  clock edges from hasher input sample to matching digest on hash_out
//  CTR_W         32  width of nonce counter, placed in the low bits of the nonce
// PORTS
//  clk          in   1       single clock, rising edge
//  rst          in   1       asynchronous, active-high reset
//  start        in   1       begin search; accepted only in IDLE with found_valid=0
//  abort        in   1       cancel search; wins over every other event except rst
//  seed         in   256     nonce template; bits [255:CTR_W] used, latched at start
//  nonce_first  in   CTR_W   first counter value, latched at start
//  nonce_last   in   CTR_W   last counter value (inclusive), latched at start
//  difficulty   in   8       required count of leading zero bits in digest, latched at start
//  hash_in      out  256     to hasher input: {seed[255:CTR_W], ctr}
//  hash_out     in   256     from hasher output
//  busy         out  1       state != IDLE
//  done         out  1       1-cycle pulse when search ends normally (range end or match)
//  exhausted    out  1       level: last search finished with no match; cleared by accepted start
//  found_valid  out  1       match result available
//  found_ready  in   1       consumer accepts result
//  found_nonce  out  256     matching nonce
//  found_hash   out  256     matching digest
// BEHAVIOUR
//  Reset (async): state=IDLE, all tags=0, ctr=0; hash_in, found_nonce, found_hash=0;
//   busy, done, exhausted, found_valid=0.
//  States: IDLE -> ISSUE on accepted start. ISSUE -> DRAIN after issuing nonce_last or on match.
//   DRAIN -> IDLE when no tag valid (done pulses that cycle). ISSUE/DRAIN -> IDLE on abort.
//  Issue: in ISSUE, hash_in carries ctr every cycle; tag[0] = 1 is pushed. ctr <= ctr+1 mod 2^CTR_W.
//   Range wraps: last < first spans through 0; last == first-1 covers the full 2^CTR_W space.
//   Outside ISSUE, hash_in holds its last value and tag[0] = 0 is pushed.
//  Tags: shift register of PIPE_LATENCY bits, aligned so tag[PIPE_LATENCY] marks the digest
//   on hash_out for the nonce driven PIPE_LATENCY cycles earlier. Retire ctr rtr starts at
//   nonce_first and increments per retired valid tag; retiring nonce = {seed_hi, rtr}.
//  Match: retiring tag valid and hash_out[255 -: difficulty] == 0; difficulty=0 matches all.
//   First match only: registered into found_* at the next edge, found_valid set, ISSUE->DRAIN.
//   Later matches (still in flight, drained) are discarded.
//  Latency: start sampled at edge E0 -> first nonce on hash_in after E0; its compare occurs
//   after E0+PIPE_LATENCY; found_valid high after E0+PIPE_LATENCY+1.
//  Handshake: found_valid held, found_* stable until found_valid & found_ready; cleared next edge.
//   found_valid survives abort and is cleared only by handshake or rst.
//  exhausted set with done when no match occurred. start when busy or found_valid=1: ignored.
//  abort: all tags cleared same edge, state IDLE, no done, exhausted unchanged. Stale digests
//   still in hasher are ignored by cleared tags.
//  start and abort same cycle in IDLE: abort wins, start dropped.
// TESTING
//  1 diff=0, first=last=5, seed_hi=0 -> one issue; found_valid after E0+65, found_nonce[31:0]=5, done.
//  2 diff=255, first=0,last=9 -> 10 consecutive issues 0..9, no found_valid; done + exhausted after E0+75.
//  3 wrap: first=FFFF_FFFE,last=1 -> hash_in[31:0] = FFFFFFFE,FFFFFFFF,0,1 on consecutive cycles.
//  4 diff=0, first=0,last=200, found_ready=0 -> found_nonce=0; issue stops; found_* stable 20 cycles;
//    start ignored; after ready pulse found_valid=0.
//  5 abort 10 cycles into ISSUE -> busy=0 next cycle, no done; new start with diff=255 sees no
//    match from old in-flight digests.
//  6 rst asserted mid-DRAIN with found_valid=1 -> all outputs 0 immediately (async), state IDLE.

Source files
------------

// File: rtl/nonce_dispatch_ctrl.sv
// nonce_dispatch_ctrl: feeds a nonce range into a pipelined SHA-256 hasher and returns the first digest meeting a leading-zero difficulty
// Ports: clk/rst (async, active-high); start/abort control; seed/nonce_first/nonce_last/difficulty latched at start;
//        hash_in to hasher, hash_out from hasher; busy/done/exhausted status; found_valid/found_ready/found_nonce/found_hash result port
module nonce_dispatch_ctrl #(
    parameter int PIPE_LATENCY = 64,
    parameter int CTR_W        = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [255:0]       seed,
    input  logic [CTR_W-1:0]   nonce_first,
    input  logic [CTR_W-1:0]   nonce_last,
    input  logic [7:0]         difficulty,
    output logic [255:0]       hash_in,
    input  logic [255:0]       hash_out,
    output logic               busy,
    output logic               done,
    output logic               exhausted,
    output logic               found_valid,
    input  logic               found_ready,
    output logic [255:0]       found_nonce,
    output logic [255:0]       found_hash
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
    state_t state, state_nx;
    logic [255-CTR_W:0] seed_hi;
    logic [CTR_W-1:0] last_r, ctr, rtr;
    logic [7:0] diff_r;
    logic [PIPE_LATENCY:1] tag;
    logic iss, got, accept, issue, retire, match, empty, finish;
    logic [255:0] mask;
    // iss is the valid bit of the nonce currently on hash_in; tag[k] follows it k cycles later
    always_comb begin
        accept   = state == IDLE && start && !found_valid && !abort;
        retire   = tag[PIPE_LATENCY];
        mask     = ~({256{1'b1}} >> diff_r);
        match    = state != IDLE && retire && !got && !abort && (hash_out & mask) == '0;
        empty    = !iss && tag == '0;
        finish   = state == DRAIN && empty && !abort;
        // hash_in already holding nonce_last means the range is fully issued
        issue    = state == ISSUE && !abort && !match && hash_in[CTR_W-1:0] != last_r;
        state_nx = abort ? IDLE :
                   accept ? ISSUE :
                   (state == ISSUE && !issue) ? DRAIN :
                   finish ? IDLE : state;
    end
    assign busy = state != IDLE;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag         <= '0;
            iss         <= 1'b0;
            got         <= 1'b0;
            seed_hi     <= '0;
            last_r      <= '0;
            diff_r      <= '0;
            ctr         <= '0;
            rtr         <= '0;
            hash_in     <= '0;
            done        <= 1'b0;
            exhausted   <= 1'b0;
            found_valid <= 1'b0;
            found_nonce <= '0;
            found_hash  <= '0;
        end else begin
            tag  <= abort ? '0 : {tag[PIPE_LATENCY-1:1], iss};
            iss  <= accept || issue;
            done <= finish;
            if (accept) begin
                seed_hi   <= seed[255:CTR_W];
                last_r    <= nonce_last;
                diff_r    <= difficulty;
                hash_in   <= {seed[255:CTR_W], nonce_first};
                ctr       <= nonce_first + CTR_W'(1);
                rtr       <= nonce_first;
                got       <= 1'b0;
                exhausted <= 1'b0;
            end
            if (issue) begin
                hash_in <= {seed_hi, ctr};
                ctr     <= ctr + CTR_W'(1);
            end
            if (retire) rtr <= rtr + CTR_W'(1);
            if (match) begin
                found_nonce <= {seed_hi, rtr};
                found_hash  <= hash_out;
                found_valid <= 1'b1;
                got         <= 1'b1;
            end else if (found_valid && found_ready) begin
                found_valid <= 1'b0;
            end
            if (finish) exhausted <= !got;
        end
    end
endmodule

// File: tb/tb_nonce_dispatch_ctrl.sv
// tb_nonce_dispatch_ctrl: directed checks of nonce_dispatch_ctrl against a 64-stage hasher model
module tb_nonce_dispatch_ctrl;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, found_ready = 1'b0;
    logic [255:0] seed = '0, hash_in, hash_out, found_nonce, found_hash;
    logic [31:0] nonce_first = '0, nonce_last = '0;
    logic [7:0] difficulty = '0;
    logic busy, done, exhausted, found_valid;
    int errors = 0, checks = 0;
    int cyc, fv;

    nonce_dispatch_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .seed(seed),
        .nonce_first(nonce_first), .nonce_last(nonce_last), .difficulty(difficulty),
        .hash_in(hash_in), .hash_out(hash_out), .busy(busy), .done(done),
        .exhausted(exhausted), .found_valid(found_valid), .found_ready(found_ready),
        .found_nonce(found_nonce), .found_hash(found_hash)
    );

    always #5 clk = ~clk;

    // stand-in digest: leading zeros controlled by the low nonce word; 0x80000000 yields all zeros
    function automatic logic [255:0] dig(input logic [255:0] x);
        return {x[31:0] ^ 32'h8000_0000, 224'h0};
    endfunction

    logic [255:0] pipe [64];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= hash_in;
            for (int i = 1; i < 64; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign hash_out = dig(pipe[63]);

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic start_search(input logic [255:0] s, input logic [31:0] f, input logic [31:0] l, input logic [7:0] d);
        @(negedge clk);
        seed = s; nonce_first = f; nonce_last = l; difficulty = d; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int c, output int v);
        c = 0; v = -1;
        while (!done && c < 400) begin
            @(posedge clk);
            #1 c++;
            if (found_valid && v < 0) v = c;
        end
        if (!done) chk("done_timeout", 256'(done), 256'(1));
    endtask

    typedef struct {
        logic [255:0] seed;
        logic [31:0]  first, last;
        logic [7:0]   diff;
        logic         found;
        logic [31:0]  nonce;
        int           fv_cyc, done_cyc;
    } vec_t;
    vec_t vt [8];

    initial begin
        vt[0] = '{{8{$urandom()}}, 32'd5,          32'd5,          8'd0,   1'b1, 32'd5,          65, 66};
        vt[1] = '{{8{$urandom()}}, 32'd0,          32'd9,          8'd255, 1'b0, 32'd0,          -1, 75};
        vt[2] = '{{8{$urandom()}}, 32'hFFFF_FFFE,  32'd1,          8'd255, 1'b0, 32'd0,          -1, 69};
        vt[3] = '{{8{$urandom()}}, 32'h7FFF_FFFE,  32'h8000_0005,  8'd31,  1'b1, 32'h8000_0000,  67, 73};
        vt[4] = '{{8{$urandom()}}, 32'h8000_0001,  32'h8000_0003,  8'd32,  1'b0, 32'd0,          -1, 68};
        vt[5] = '{{8{$urandom()}}, 32'h8000_0001,  32'h8000_0001,  8'd31,  1'b1, 32'h8000_0001,  65, 66};
        vt[6] = '{{8{$urandom()}}, 32'd0,          32'd200,        8'd0,   1'b1, 32'd0,          65, 130};
        vt[7] = '{{8{$urandom()}}, 32'h8000_0000,  32'h8000_0000,  8'd255, 1'b1, 32'h8000_0000,  65, 66};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_flags", 256'({busy, done, exhausted, found_valid}), 256'(0));
        chk("reset_hash_in", hash_in, '0);
        chk("reset_found_nonce", found_nonce, '0);
        chk("reset_found_hash", found_hash, '0);
        @(negedge clk) rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            start_search(vt[i].seed, vt[i].first, vt[i].last, vt[i].diff);
            chk($sformatf("v%0d_busy", i), 256'(busy), 256'(1));
            wait_done(cyc, fv);
            chk($sformatf("v%0d_done_cyc", i), 256'(cyc), 256'(vt[i].done_cyc));
            chk($sformatf("v%0d_fv_cyc", i), 256'(fv), 256'(vt[i].fv_cyc));
            chk($sformatf("v%0d_found_valid", i), 256'(found_valid), 256'(vt[i].found));
            chk($sformatf("v%0d_exhausted", i), 256'(exhausted), 256'(!vt[i].found));
            if (vt[i].found) begin
                chk($sformatf("v%0d_nonce", i), found_nonce, {vt[i].seed[255:32], vt[i].nonce});
                chk($sformatf("v%0d_hash", i), found_hash, dig({vt[i].seed[255:32], vt[i].nonce}));
            end
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_done_pulse", i), 256'({done, busy}), 256'(0));
            @(negedge clk) found_ready = 1'b1;
            @(posedge clk);
            #1 found_ready = 1'b0;
            chk($sformatf("v%0d_fv_cleared", i), 256'(found_valid), 256'(0));
        end

        begin
            logic [31:0] wexp [4];
            wexp = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};
            start_search('0, 32'hFFFF_FFFE, 32'd1, 8'd255);
            for (int i = 0; i < 4; i++) begin
                if (i > 0) begin
                    @(posedge clk);
                    #1;
                end
                chk($sformatf("wrap_%0d", i), 256'(hash_in[31:0]), 256'(wexp[i]));
            end
            @(posedge clk);
            #1 chk("wrap_hold", 256'(hash_in[31:0]), 256'(32'h1));
            wait_done(cyc, fv);
        end

        begin
            logic [255:0] n, h, hi;
            logic ok;
            start_search({8{32'hA5A5_5A5A}}, 32'd0, 32'd200, 8'd0);
            cyc = 0;
            while (!found_valid && cyc < 100) begin
                @(posedge clk);
                #1 cyc++;
            end
            chk("hold_fv_cyc", 256'(cyc), 256'(65));
            chk("hold_nonce", found_nonce, {{7{32'hA5A5_5A5A}}, 32'd0});
            chk("hold_issue_stop", 256'(hash_in[31:0]), 256'(64));
            n = found_nonce; h = found_hash; hi = hash_in; ok = 1'b1;
            for (int i = 0; i < 20; i++) begin
                @(posedge clk);
                #1 ok = ok && found_valid && found_nonce == n && found_hash == h && hash_in == hi;
            end
            chk("hold_stable20", 256'(ok), 256'(1));
            wait_done(cyc, fv);
            @(negedge clk) start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            chk("hold_start_ignored", 256'({busy, found_valid}), 256'(2'b01));
            @(negedge clk) found_ready = 1'b1;
            @(posedge clk);
            #1 found_ready = 1'b0;
            chk("hold_released", 256'(found_valid), 256'(0));
        end

        start_search('0, 32'h8000_0000, 32'h8000_00FF, 8'd0);
        repeat (10) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        chk("abort_idle", 256'({busy, done, found_valid, exhausted}), 256'(0));
        start_search('0, 32'd0, 32'd3, 8'd255);
        wait_done(cyc, fv);
        chk("abort_new_done_cyc", 256'(cyc), 256'(69));
        chk("abort_no_stale_match", 256'(fv), 256'(-1));
        chk("abort_new_exhausted", 256'(exhausted), 256'(1));

        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; abort = 1'b0;
        chk("start_abort_same", 256'({busy, exhausted}), 256'(2'b01));

        start_search({8{32'h1234_5678}}, 32'd0, 32'd200, 8'd0);
        cyc = 0;
        while (!found_valid && cyc < 100) begin
            @(posedge clk);
            #1 cyc++;
        end
        repeat (5) @(posedge clk);
        #1 chk("rst_pre_drain", 256'({busy, found_valid}), 256'(2'b11));
        @(negedge clk) rst = 1'b1;
        #1;
        chk("rst_async_flags", 256'({busy, done, exhausted, found_valid}), 256'(0));
        chk("rst_async_data", hash_in | found_nonce | found_hash, '0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1 chk("rst_after", 256'({busy, found_valid}), 256'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
